// File: rtl/key_pkg.sv
// Shared types and default timing for the key event decoder.
// The default timing constants assume a 50 MHz clock.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HELD  = 3'd1,
    LONG  = 3'd2,
    WAIT2 = 3'd3,
    HELD2 = 3'd4
  } key_state_t;

  // Release gap sits slightly above the 2^24-cycle auto-repeat period.
  localparam int GAP_TIMEOUT_DEF   = 17_000_000;
  localparam int DCLICK_WINDOW_DEF = 12_500_000;
  localparam int LONG_PULSES_DEF   = 4;

endpackage

// File: rtl/key_event_fsm.sv
// Single-key click / double-click / long-press classifier.
// Optional evt_repeat generation in LONG is enabled by defining KEY_REPEAT_EN.
module key_event_fsm
  import key_pkg::*;
#(
  parameter int CNT_W         = 26,
  parameter int GAP_TIMEOUT   = GAP_TIMEOUT_DEF,
  parameter int DCLICK_WINDOW = DCLICK_WINDOW_DEF,
  parameter int LONG_PULSES   = LONG_PULSES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_pulse,
  output logic evt_click,
  output logic evt_dclick,
  output logic evt_long,
  output logic evt_repeat,
  output logic busy
);

  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] WIN_T   = CNT_W'(DCLICK_WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LONG_T  = 4'(LONG_PULSES);

  key_state_t       state_q, state_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;
  logic [3:0]       pcnt_inc;
  logic [CNT_W-1:0] gcnt_inc;
  logic [CNT_W-1:0] wcnt_inc;

  // All counters saturate instead of wrapping.
  assign pcnt_inc = (pcnt_q == 4'hF)    ? pcnt_q : pcnt_q + 4'd1;
  assign gcnt_inc = (gcnt_q == CNT_MAX) ? gcnt_q : gcnt_q + CNT_W'(1);
  assign wcnt_inc = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + CNT_W'(1);

`ifdef KEY_REPEAT_EN
  logic repeat_q, repeat_d;
`endif

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    wcnt_d   = wcnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_d = 1'b0;
`endif
    // A pulse always takes priority over a timeout decided on the same edge.
    unique case (state_q)
      IDLE: begin
        if (key_pulse) begin
          state_d = HELD;
          pcnt_d  = 4'd1;
          gcnt_d  = '0;
        end
      end
      HELD: begin
        if (key_pulse) begin
          gcnt_d = '0;
          pcnt_d = pcnt_inc;
          if (pcnt_inc == LONG_T) begin
            long_d  = 1'b1;
            state_d = LONG;
          end
        end else begin
          gcnt_d = gcnt_inc;
          if (gcnt_inc == GAP_T) begin
            state_d = WAIT2;
            wcnt_d  = '0;
          end
        end
      end
      WAIT2: begin
        if (key_pulse) begin
          dclick_d = 1'b1;
          state_d  = HELD2;
          gcnt_d   = '0;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == WIN_T) begin
            click_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LONG, HELD2: begin
        if (key_pulse) begin
          gcnt_d = '0;
`ifdef KEY_REPEAT_EN
          repeat_d = (state_q == LONG);
`endif
        end else begin
          gcnt_d = gcnt_inc;
          if (gcnt_inc == GAP_T) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      pcnt_d = '0;
      gcnt_d = '0;
      wcnt_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      wcnt_q   <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      wcnt_q   <= wcnt_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign evt_repeat = repeat_q;
`else
  assign evt_repeat = 1'b0;
`endif

  assign evt_click  = click_q;
  assign evt_dclick = dclick_q;
  assign evt_long   = long_q;
  assign busy       = busy_q;

endmodule

// File: rtl/key_event_decoder.sv
// Multi-key event decoder: one independent key_event_fsm per key.
// Define KEY_REPEAT_EN to enable evt_repeat pulses during a long press.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int KEY_NUM       = 3,
  parameter int CNT_W         = 26,
  parameter int GAP_TIMEOUT   = GAP_TIMEOUT_DEF,
  parameter int DCLICK_WINDOW = DCLICK_WINDOW_DEF,
  parameter int LONG_PULSES   = LONG_PULSES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_pulse,
  output logic [KEY_NUM-1:0] evt_click,
  output logic [KEY_NUM-1:0] evt_dclick,
  output logic [KEY_NUM-1:0] evt_long,
  output logic [KEY_NUM-1:0] evt_repeat,
  output logic [KEY_NUM-1:0] busy
);

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    key_event_fsm #(
      .CNT_W        (CNT_W),
      .GAP_TIMEOUT  (GAP_TIMEOUT),
      .DCLICK_WINDOW(DCLICK_WINDOW),
      .LONG_PULSES  (LONG_PULSES)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_pulse (key_pulse[k]),
      .evt_click (evt_click[k]),
      .evt_dclick(evt_dclick[k]),
      .evt_long  (evt_long[k]),
      .evt_repeat(evt_repeat[k]),
      .busy      (busy[k])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with short timing parameters
// (GAP 10, window 20, long press at 3 pulses); honours KEY_REPEAT_EN.
module tb_key_event_decoder;

  localparam int CLK_HALF = 5;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] cl;
    logic [2:0] dc;
    logic [2:0] lg;
    logic [2:0] rp;
    logic [2:0] bz;
  } exp_t;

`ifdef KEY_REPEAT_EN
  localparam logic [2:0] REP_K2 = 3'b100;
`else
  localparam logic [2:0] REP_K2 = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_pulse;
  logic [2:0] evt_click, evt_dclick, evt_long, evt_repeat, busy;

  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  key_event_decoder #(
    .KEY_NUM(3), .CNT_W(26), .GAP_TIMEOUT(10), .DCLICK_WINDOW(20), .LONG_PULSES(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_pulse (key_pulse),
    .evt_click (evt_click),
    .evt_dclick(evt_dclick),
    .evt_long  (evt_long),
    .evt_repeat(evt_repeat),
    .busy      (busy)
  );

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every negedge after edge E sees edge_n == E.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == edge_n) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (evt_click !== e.cl || evt_dclick !== e.dc || evt_long !== e.lg ||
            evt_repeat !== e.rp || busy !== e.bz) begin
          miscompares++;
          $display("[TB] FAIL %s @E%0d: got click=%b dclick=%b long=%b rep=%b busy=%b, want %b %b %b %b %b",
                   e.name, edge_n, evt_click, evt_dclick, evt_long, evt_repeat, busy,
                   e.cl, e.dc, e.lg, e.rp, e.bz);
        end
      end else if (|{evt_click, evt_dclick, evt_long, evt_repeat}) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event @E%0d: got click=%b dclick=%b long=%b rep=%b, want none",
                 edge_n, evt_click, evt_dclick, evt_long, evt_repeat);
      end
    end
  end

  task automatic push_exp(input int c, input string n, input logic [2:0] cl,
                          input logic [2:0] dc, input logic [2:0] lg,
                          input logic [2:0] rp, input logic [2:0] bz);
    exp_t e;
    e.cyc = c; e.name = n; e.cl = cl; e.dc = dc; e.lg = lg; e.rp = rp; e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Drive mask so that it is sampled exactly at edge e.
  task automatic apply_stimulus(input int e, input logic [2:0] m);
    if (edge_n > e - 1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL stim_late: now E%0d, want at most E%0d", edge_n, e - 1);
    end
    wait_edge(e - 1);
    key_pulse = m;
    @(negedge clk);
    key_pulse = 3'b000;
  endtask

  initial begin
    #(CLK_HALF * 2 * 20000);
    $display("[TB] FAIL watchdog: simulation ran out of time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    key_pulse = 3'b000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({evt_click, evt_dclick, evt_long, evt_repeat, busy} !== 15'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b, want all zero",
               {evt_click, evt_dclick, evt_long, evt_repeat, busy});
    end
    rst_n = 1'b1;
    mon_en = 1'b1;

    $display("[TB] single click on key0");
    b = edge_n + 2;
    push_exp(b,      "click_start", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 10, "click_wait2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 29, "click_early", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 30, "click_evt",   3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    push_exp(b + 31, "click_after", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b001);
    wait_edge(b + 33);

    $display("[TB] double click on key1");
    b = edge_n + 2;
    push_exp(b + 14, "dclk_wait2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
    push_exp(b + 15, "dclk_evt",   3'b000, 3'b010, 3'b000, 3'b000, 3'b010);
    push_exp(b + 24, "dclk_held2", 3'b000, 3'b000, 3'b000, 3'b000, 3'b010);
    push_exp(b + 25, "dclk_idle",  3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b010);
    apply_stimulus(b + 15, 3'b010);
    wait_edge(b + 50);

    $display("[TB] long press on key2");
    b = edge_n + 2;
    push_exp(b + 5,  "long_two",    3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
    push_exp(b + 10, "long_evt",    3'b000, 3'b000, 3'b100, 3'b000, 3'b100);
    push_exp(b + 15, "long_repeat", 3'b000, 3'b000, 3'b000, REP_K2, 3'b100);
    push_exp(b + 24, "long_hold",   3'b000, 3'b000, 3'b000, 3'b000, 3'b100);
    push_exp(b + 25, "long_idle",   3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b100);
    apply_stimulus(b + 5, 3'b100);
    apply_stimulus(b + 10, 3'b100);
    apply_stimulus(b + 15, 3'b100);
    wait_edge(b + 50);

    // Pulse on the gap-timeout edge keeps HELD; the third pulse then proves pcnt was 2.
    $display("[TB] tie: pulse on gap timeout edge");
    b = edge_n + 2;
    push_exp(b + 10, "tie_gap_held", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 15, "tie_gap_long", 3'b000, 3'b000, 3'b001, 3'b000, 3'b001);
    push_exp(b + 25, "tie_gap_idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b001);
    apply_stimulus(b + 10, 3'b001);
    apply_stimulus(b + 15, 3'b001);
    wait_edge(b + 50);

    $display("[TB] tie: pulse on last window edge");
    b = edge_n + 2;
    push_exp(b + 29, "tie_win_wait", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 30, "tie_win_dclk", 3'b000, 3'b001, 3'b000, 3'b000, 3'b001);
    push_exp(b + 39, "tie_win_h2",   3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 40, "tie_win_idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b001);
    apply_stimulus(b + 30, 3'b001);
    wait_edge(b + 60);

    $display("[TB] reset mid-operation");
    b = edge_n + 2;
    push_exp(b + 4,  "rst_busy",    3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 8,  "rst_cleared", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    push_exp(b + 30, "rst_noclick", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    push_exp(b + 60, "rst_quiet",   3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b001);
    wait_edge(b + 5);
    rst_n = 1'b0;
    wait_edge(b + 7);
    rst_n = 1'b1;
    wait_edge(b + 62);

    $display("[TB] simultaneous keys");
    b = edge_n + 2;
    push_exp(b,      "sim_start", 3'b000, 3'b000, 3'b000, 3'b000, 3'b011);
    push_exp(b + 10, "sim_long1", 3'b000, 3'b000, 3'b010, 3'b000, 3'b011);
    push_exp(b + 20, "sim_idle1", 3'b000, 3'b000, 3'b000, 3'b000, 3'b001);
    push_exp(b + 30, "sim_click", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    apply_stimulus(b, 3'b011);
    apply_stimulus(b + 5, 3'b010);
    apply_stimulus(b + 10, 3'b010);
    wait_edge(b + 35);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumer side of the key debounce/auto-repeat stage. Takes per-key active-high one-cycle repeat pulses, which arrive at press-confirm and then periodically while the key is held.
- Classifies each key's activity into single-click, double-click and long-press events, each emitted as a one-cycle output pulse.
- Sits between the key front-end and application control logic (menus, LED modes).
- Each key is handled by an independent FSM.

Parameters:
- KEY_NUM, 3: number of keys.
- CNT_W, 26: width of the gap and window counters.
- GAP_TIMEOUT, 17_000_000: consecutive pulse-free cycles that mean "key released". Slightly above the 2^24-cycle repeat period.
- DCLICK_WINDOW, 12_500_000: pulse-free cycles after release during which a new press counts as a double-click.
- LONG_PULSES, 4: pulses within one hold that make it a long press. Legal range 2..15.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: reset.
- key_pulse, input, KEY_NUM: one-cycle active-high press/repeat pulses, one bit per key.
- evt_click, output, KEY_NUM: one-cycle pulse per key on a single click.
- evt_dclick, output, KEY_NUM: one-cycle pulse per key on a double-click.
- evt_long, output, KEY_NUM: one-cycle pulse per key when a long press is reached.
- evt_repeat, output, KEY_NUM: repeat pulse during a long press (see optional feature).
- busy, output, KEY_NUM: high while that key's FSM is not IDLE.

Reset and clocking (already decided):
- Reset is rst_n, asynchronous, active-low.
- Clock is clk.

Behaviour:
- Reset values: all outputs 0, all FSMs IDLE, all counters 0.
- Reset asserted mid-operation aborts the activity with no event emitted, including a pending click.
- Timing convention: pulses are sampled at edge E0. All event outputs are registered: set by the edge that makes the decision, high for exactly one cycle, then cleared.
- Per-key states: IDLE, HELD, LONG, WAIT2, HELD2.
- IDLE:
  - On a pulse, go to HELD with pcnt=1 and gcnt=0.
- HELD:
  - On a pulse: gcnt=0 and pcnt++.
  - If the new pcnt equals LONG_PULSES: emit evt_long and go to LONG.
  - On a pulse-free edge: gcnt++.
  - When gcnt reaches GAP_TIMEOUT: go to WAIT2 with wcnt=0.
- WAIT2:
  - On a pulse: emit evt_dclick and go to HELD2 with gcnt=0.
  - On a pulse-free edge: wcnt++.
  - When wcnt reaches DCLICK_WINDOW: emit evt_click and go to IDLE.
- LONG:
  - On a pulse: gcnt=0, plus evt_repeat when the feature is enabled.
  - When gcnt reaches GAP_TIMEOUT: go to IDLE. No click is emitted.
- HELD2:
  - On a pulse: gcnt=0.
  - When gcnt reaches GAP_TIMEOUT: go to IDLE. A third press never yields a further event.
- Tie rules:
  - A pulse on the edge where a timeout would fire wins. The key stays held, or a double-click is emitted in WAIT2.
  - A pulse on the edge where pcnt reaches LONG_PULSES emits evt_long only.
- Width and counting rules:
  - Counters stop counting at their terminal value; no wrap-around.
  - pcnt is 4 bits and saturates.
- Keys are fully independent. Simultaneous pulses on several keys each produce their own events on the same cycle.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in LONG, each further input pulse produces a one-cycle evt_repeat pulse on the following cycle.
- Undefined: evt_repeat is tied to 0 and no repeat logic is synthesized. The port list is unchanged.

Decomposition:
- Shared package key_pkg holds:
  - the state enum key_state_t (IDLE, HELD, LONG, WAIT2, HELD2);
  - the default timing constants GAP_TIMEOUT_DEF and DCLICK_WINDOW_DEF;
  - LONG_PULSES_DEF.
- Sub-module key_event_fsm: the single-key FSM with its counters. The top instantiates it KEY_NUM times in a generate loop and concatenates the outputs.

Test Plan:
All scenarios use KEY_NUM=3, GAP_TIMEOUT=10, DCLICK_WINDOW=20, LONG_PULSES=3.
- Single click: pulse on key0 at E0 -> evt_click[0] high for one cycle after E30; no other events; busy[0] low after E30.
- Double-click: key1 pulses at E0 and E15 -> evt_dclick[1] high after E15; no evt_click ever; IDLE after E25.
- Long press: key2 pulses at E0, E5, E10 -> evt_long[2] after E10. Further pulse at E15 -> evt_repeat[2] after E15 only with KEY_REPEAT_EN defined. IDLE at E25 with no click.
- Tie cases:
  - Key0 pulses at E0 and E10 -> stays HELD with pcnt=2, no release.
  - Key0 pulse at E0, then next pulse exactly at the last window edge (E30) -> evt_dclick, no evt_click.
- Reset mid-operation: key0 pulse at E0, rst_n low between E5 and E7 -> all outputs 0, no event through E60.
- Simultaneous keys: key0 single click and key1 long press started at the same E0 -> events appear independently at their expected edges.
